// File: rtl/approx_pkg.sv
// Shared constants, ALU opcodes and the saturation helper for the 1/x series datapath.
package approx_pkg;

  localparam int WIDTH = 16;
  localparam int FRAC  = 14;
  localparam int NW    = 8;
  localparam int N_MAX = 32;
  localparam int EPS   = 4;

  localparam logic signed [WIDTH-1:0]   ONE     = WIDTH'(1 << FRAC);
  localparam logic signed [2*WIDTH-1:0] ONE_W   = (2*WIDTH)'(1 << FRAC);
  localparam logic signed [WIDTH-1:0]   W_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0]   W_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [2*WIDTH-1:0] SAT_HI  = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] SAT_LO  = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    ADD_ONE  = 3'd0,
    SUB_ONE  = 3'd1,
    ADD_SUB  = 3'd2,
    MULTIPLY = 3'd3,
    ALU_IDLE = 3'd4
  } alu_op_e;

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [2*WIDTH-1:0] v);
    if (v > SAT_HI)      sat = W_MAX;
    else if (v < SAT_LO) sat = W_MIN;
    else                 sat = v[WIDTH-1:0];
  endfunction

endpackage

// File: rtl/approx_alu.sv
// Fixed-point ALU with a single result register; result appears one cycle after the opcode.
module approx_alu
  import approx_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              mode_i,
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  input  logic                    sub_i,
  output logic signed [WIDTH-1:0] alu_r_o
);

  logic signed [2*WIDTH-1:0] a_w, b_w, prod;
  logic signed [WIDTH-1:0]   alu_nxt;

  assign a_w  = {{WIDTH{a_i[WIDTH-1]}}, a_i};
  assign b_w  = {{WIDTH{b_i[WIDTH-1]}}, b_i};
  assign prod = a_w * b_w;

  always_comb begin
    alu_nxt = alu_r_o;
    case (mode_i)
      ADD_ONE:  alu_nxt = a_i + 16'sd1;
      SUB_ONE:  alu_nxt = sat(a_w - ONE_W);
      ADD_SUB:  alu_nxt = sub_i ? sat(a_w - b_w) : sat(a_w + b_w);
      MULTIPLY: alu_nxt = sat(prod >>> FRAC);
      default:  alu_nxt = alu_r_o;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) alu_r_o <= '0;
    else      alu_r_o <= alu_nxt;
  end

endmodule

// File: rtl/approx_datapath.sv
// Register file, A/B operand muxing and termination check for the 1/x series approximation.
module approx_datapath
  import approx_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             busy_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [2:0]       mode_i,
  input  logic             check_for_termination_i,
  input  logic             wren_x1_i,
  input  logic             wren_x1_n_i,
  input  logic             wren_y_i,
  input  logic             wren_n_i,
  input  logic             wren_sigma_n_i,
  input  logic             x_to_alu_a_i,
  input  logic             y_to_alu_a_i,
  input  logic             x1_to_alu_a_i,
  input  logic             n_to_alu_a_i,
  input  logic             x1_n_to_alu_b_i,
  input  logic             sigma_n_to_alu_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic [NW-1:0]    n_o
);

  logic signed [WIDTH-1:0] x, y, x1, x1_n, alu_a, alu_b, alu_r;
  logic [WIDTH-1:0]        mag;
  logic [NW-1:0]           n;
  logic                    sigma_n, start_acc, done;

  assign start_acc = start_i & ~busy_i;

  always_comb begin
    alu_a = '0;
    if (x_to_alu_a_i)       alu_a = x;
    else if (y_to_alu_a_i)  alu_a = y;
    else if (x1_to_alu_a_i) alu_a = x1;
    else if (n_to_alu_a_i)  alu_a = {{(WIDTH-NW){1'b0}}, n};
  end

  assign alu_b = x1_n_to_alu_b_i ? x1_n : '0;

  approx_alu u_alu (
    .clk     (clk),
    .rst     (rst),
    .mode_i  (mode_i),
    .a_i     (alu_a),
    .b_i     (alu_b),
    .sub_i   (sigma_n_to_alu_i & sigma_n),
    .alu_r_o (alu_r)
  );

  // The most-negative value has no positive twin; clamp it to max magnitude.
  always_comb begin
    if (x1_n == W_MIN)      mag = W_MAX;
    else if (x1_n[WIDTH-1]) mag = -x1_n;
    else                    mag = x1_n;
  end

  assign done = (mag < WIDTH'(EPS)) || (n >= NW'(N_MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x       <= '0;
      y       <= '0;
      x1      <= '0;
      x1_n    <= '0;
      n       <= '0;
      sigma_n <= 1'b0;
      valid_o <= 1'b0;
    end else if (start_acc) begin
      x       <= x_i;
      y       <= ONE;
      n       <= NW'(1);
      sigma_n <= 1'b1;
      valid_o <= 1'b0;
    end else begin
      if (wren_x1_i)      x1      <= alu_r;
      if (wren_x1_n_i)    x1_n    <= alu_r;
      if (wren_y_i)       y       <= alu_r;
      if (wren_n_i)       n       <= alu_r[NW-1:0];
      if (wren_sigma_n_i) sigma_n <= ~sigma_n;
      valid_o <= check_for_termination_i & done;
    end
  end

  assign result_o = y;
  assign n_o      = n;

endmodule

// File: tb/tb_approx_datapath.sv
// Directed bench: acts as the controller and checks results against hand-computed series values.
module tb_approx_datapath;
  import approx_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, busy_i;
  logic [15:0] x_i;
  logic [2:0]  mode_i;
  logic        check_for_termination_i;
  logic        wren_x1_i, wren_x1_n_i, wren_y_i, wren_n_i, wren_sigma_n_i;
  logic        x_to_alu_a_i, y_to_alu_a_i, x1_to_alu_a_i, n_to_alu_a_i;
  logic        x1_n_to_alu_b_i, sigma_n_to_alu_i;
  logic        valid_o;
  logic [15:0] result_o;
  logic [7:0]  n_o;

  int checks = 0;
  int failures = 0;
  logic [15:0] yq[$];
  logic        sq[$];
  int          its;
  logic        fin;

  always #5 clk = ~clk;

  approx_datapath dut (
    .clk(clk), .rst(rst), .start_i(start_i), .busy_i(busy_i), .x_i(x_i), .mode_i(mode_i),
    .check_for_termination_i(check_for_termination_i),
    .wren_x1_i(wren_x1_i), .wren_x1_n_i(wren_x1_n_i), .wren_y_i(wren_y_i),
    .wren_n_i(wren_n_i), .wren_sigma_n_i(wren_sigma_n_i),
    .x_to_alu_a_i(x_to_alu_a_i), .y_to_alu_a_i(y_to_alu_a_i),
    .x1_to_alu_a_i(x1_to_alu_a_i), .n_to_alu_a_i(n_to_alu_a_i),
    .x1_n_to_alu_b_i(x1_n_to_alu_b_i), .sigma_n_to_alu_i(sigma_n_to_alu_i),
    .valid_o(valid_o), .result_o(result_o), .n_o(n_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear();
    start_i = 0; mode_i = ALU_IDLE; check_for_termination_i = 0;
    wren_x1_i = 0; wren_x1_n_i = 0; wren_y_i = 0; wren_n_i = 0; wren_sigma_n_i = 0;
    x_to_alu_a_i = 0; y_to_alu_a_i = 0; x1_to_alu_a_i = 0; n_to_alu_a_i = 0;
    x1_n_to_alu_b_i = 0; sigma_n_to_alu_i = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic start_op(input logic [15:0] xv);
    clear(); busy_i = 0; start_i = 1; x_i = xv;
    cyc();
    clear(); busy_i = 1;
  endtask

  task automatic prologue();
    clear(); mode_i = SUB_ONE; x_to_alu_a_i = 1; cyc();
    clear(); wren_x1_i = 1; wren_x1_n_i = 1; cyc();
    clear();
  endtask

  task automatic iter(output logic v);
    clear(); mode_i = ADD_SUB; y_to_alu_a_i = 1; x1_n_to_alu_b_i = 1; sigma_n_to_alu_i = 1; cyc();
    clear(); mode_i = ADD_ONE; n_to_alu_a_i = 1; wren_y_i = 1; cyc();
    clear(); mode_i = MULTIPLY; x1_to_alu_a_i = 1; x1_n_to_alu_b_i = 1;
    wren_n_i = 1; wren_sigma_n_i = 1; cyc();
    clear(); wren_x1_n_i = 1; cyc();
    clear(); check_for_termination_i = 1; cyc();
    v = valid_o;
    yq.push_back(result_o);
    sq.push_back(dut.sigma_n);
    clear();
  endtask

  task automatic run(input logic [15:0] xv, input string tag, output int n_it, output logic ok);
    logic v;
    yq.delete(); sq.delete();
    start_op(xv);
    prologue();
    n_it = 0; v = 0;
    while (!v && n_it < 40) begin
      iter(v);
      n_it++;
    end
    ok = v;
    check({tag, "_terminated"}, {31'd0, v}, 32'd1);
    busy_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0; busy_i = 0; x_i = 0; clear();
    #12;
    check("reset_result", {16'd0, result_o}, 32'd0);
    check("reset_n", {24'd0, n_o}, 32'd0);
    check("reset_valid", {31'd0, valid_o}, 32'd0);
    @(negedge clk); rst = 1;

    // x = 1.0: first term is zero, so the first check terminates
    run(16'd16384, "x1p0", its, fin);
    check("x1p0_iters", its, 32'd1);
    check("x1p0_result", {16'd0, result_o}, 32'd16384);
    check("x1p0_n", {24'd0, n_o}, 32'd2);
    cyc();
    check("x1p0_valid_one_cycle", {31'd0, valid_o}, 32'd0);

    // x = 1.25
    run(16'd20480, "x1p25", its, fin);
    check("x1p25_y0", {16'd0, yq[0]}, 32'd12288);
    check("x1p25_y1", {16'd0, yq[1]}, 32'd13312);
    check("x1p25_y2", {16'd0, yq[2]}, 32'd13056);
    check("x1p25_iters", its, 32'd6);
    check("x1p25_result", {16'd0, result_o}, 32'd13108);
    check("x1p25_n", {24'd0, n_o}, 32'd7);

    // x = 1.5: sigma_n toggles once per term
    run(16'd24576, "x1p5", its, fin);
    check("x1p5_y0", {16'd0, yq[0]}, 32'd8192);
    check("x1p5_y1", {16'd0, yq[1]}, 32'd12288);
    check("x1p5_y2", {16'd0, yq[2]}, 32'd10240);
    check("x1p5_sigma0", {31'd0, sq[0]}, 32'd0);
    check("x1p5_sigma1", {31'd0, sq[1]}, 32'd1);
    check("x1p5_sigma2", {31'd0, sq[2]}, 32'd0);
    check("x1p5_iters", its, 32'd12);
    check("x1p5_result", {16'd0, result_o}, 32'd10924);
    check("x1p5_n", {24'd0, n_o}, 32'd13);
    cyc();
    check("x1p5_valid_one_cycle", {31'd0, valid_o}, 32'd0);
    check("x1p5_result_stable", {16'd0, result_o}, 32'd10924);

    // x ~ 0.02: saturates, ends on the iteration limit
    run(16'd328, "x0p02", its, fin);
    check("x0p02_y0", {16'd0, yq[0]}, 32'd32440);
    check("x0p02_y1_sat", {16'd0, yq[1]}, 32'd32767);
    check("x0p02_iters", its, 32'd31);
    check("x0p02_result", {16'd0, result_o}, 32'd32767);
    check("x0p02_n", {24'd0, n_o}, 32'd32);

    // start while busy is ignored
    clear(); busy_i = 1; start_i = 1; x_i = 16'd20480; cyc();
    clear();
    check("busy_start_n", {24'd0, n_o}, 32'd32);
    check("busy_start_y", {16'd0, result_o}, 32'd32767);
    // x still 328; x beats y on the A bus: y <= 328 - 16384 = -16056
    mode_i = SUB_ONE; x_to_alu_a_i = 1; y_to_alu_a_i = 1; cyc();
    clear(); wren_y_i = 1; cyc();
    clear();
    check("busy_x_kept_prio", {16'd0, result_o}, 32'd49480);
    // no A select gives 0, so ADD_ONE yields 1
    mode_i = ADD_ONE; cyc();
    clear(); wren_n_i = 1; cyc();
    clear();
    check("no_sel_a_zero", {24'd0, n_o}, 32'd1);
    // start acceptance beats a same-cycle wren_y
    mode_i = SUB_ONE; x_to_alu_a_i = 1; cyc();
    clear(); busy_i = 0; start_i = 1; x_i = 16'd16384; wren_y_i = 1; cyc();
    clear();
    check("start_over_wren_y", {16'd0, result_o}, 32'd16384);
    check("start_over_wren_n", {24'd0, n_o}, 32'd1);

    // reset right after a terminating check clears valid immediately
    start_op(16'd16384);
    prologue();
    iter(fin);
    check("rst_pre_valid", {31'd0, fin}, 32'd1);
    rst = 0;
    #1;
    check("rst_mid_valid", {31'd0, valid_o}, 32'd0);
    check("rst_mid_result", {16'd0, result_o}, 32'd0);
    check("rst_mid_n", {24'd0, n_o}, 32'd0);
    clear(); busy_i = 0;
    @(negedge clk); rst = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rst_post_no_valid", {31'd0, valid_o}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/approx_datapath.md
Name: approx_datapath

Overview:
Register file, fixed-point ALU and termination checker for the series approximation 1/x = sum over n of (-1)^n * (x-1)^n.
- Sits directly downstream of the approximation controller and consumes its mode, register-transfer and write-enable strobes.
- Returns valid_o to the controller's valid_i to end the iteration.
- Exposes the final result to the system.

Parameters:
WIDTH, 16, data width of x, y, x1, x1_n (signed two's complement fixed point)
FRAC, 14, fractional bits; ONE = 1<<FRAC
NW, 8, width of iteration counter n (unsigned)
N_MAX, 32, iteration limit; forces termination when n >= N_MAX
EPS, 4, termination threshold in LSBs on |x1_n|

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
start_i  in  1  load request; accepted only while busy_i=0
busy_i  in  1  controller busy
x_i  in  WIDTH  operand x, sampled on start acceptance
mode_i  in  3  ALU opcode from controller
check_for_termination_i  in  1  evaluate termination this cycle
wren_x1_i, wren_x1_n_i, wren_y_i, wren_n_i, wren_sigma_n_i  in  1 each  write enables
x_to_alu_a_i, y_to_alu_a_i, x1_to_alu_a_i, n_to_alu_a_i  in  1 each  ALU A-bus select
x1_n_to_alu_b_i  in  1  drive x1_n on ALU B bus (else B=0)
sigma_n_to_alu_i  in  1  ADD_SUB uses sigma_n as sign (else add)
valid_o  out  1  one-cycle pulse: result final
result_o  out  WIDTH  y register
n_o  out  NW  current n

Behaviour:
- Reset (rst=0, async): x=0, y=0, x1=0, x1_n=0, n=0, sigma_n=0, alu_r=0, valid_o=0.
- Start accept (start_i & ~busy_i), synchronous load:
  - x<=x_i, y<=ONE, n<=1, sigma_n<=1 (subtract), valid_o<=0.
  - Ignored while busy_i=1.
- A-bus mux, fixed priority x > y > x1 > n:
  - n is zero-extended to WIDTH.
  - No select active gives A=0.
- ALU result register alu_r, latency 1: opcode in cycle t, result in alu_r at t+1, write-enabled strobes in t+1 store alu_r.
- Opcodes:
  - ADD_ONE: A + 1 LSB (integer increment of n).
  - SUB_ONE: A - ONE.
  - ADD_SUB: A - B if sigma_n_to_alu_i & sigma_n, else A + B.
  - MULTIPLY: (A*B) signed, full 2*WIDTH product, arithmetic shift right FRAC, truncated.
  - ALU_IDLE or undefined code: alu_r holds.
- Width rules:
  - All ADD_SUB, SUB_ONE and MULTIPLY results saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - ADD_ONE on n wraps modulo 2^NW.
- Write enables:
  - wren_x1 and wren_x1_n: store alu_r (both may fire together).
  - wren_y: stores alu_r.
  - wren_n: stores alu_r[NW-1:0].
  - wren_sigma_n: toggles sigma_n. It does not load alu_r.
- Simultaneous writes to distinct registers all take effect. start acceptance overrides any write enable in the same cycle.
- Expected controller sequence: SUB1, WB, then loop ADDSUB, ADD, MULT, WB2, ENDIT (5 cycles per term).
- Termination, on check_for_termination_i=1:
  - Condition: |x1_n| < EPS or n >= N_MAX (x1_n is the next term).
  - If true, valid_o=1 next cycle for exactly one cycle; otherwise 0.
  - |most-negative| is treated as max magnitude, so it never terminates via EPS.
- result_o is continuously y and stays stable after valid_o until the next start acceptance.
- Reset mid-operation clears everything immediately; no pulse on valid_o.

Decomposition:
- Package approx_pkg holds:
  - opcodes ADD_ONE=0, SUB_ONE=1, ADD_SUB=2, MULTIPLY=3, ALU_IDLE=4;
  - ONE derivation;
  - saturation helper function.
- Sub-module approx_alu holds mux output operands, opcode, saturation and alu_r.
- The register file and termination logic stay in approx_datapath.

Test Plan:
- Reset: rst=0 during activity -> all registers 0, valid_o=0 within the same cycle, no valid pulse after release.
- x_i=16384 (1.0): x1=0, y after first ADDSUB = 16384; first ENDIT sees x1_n=0 -> valid_o pulse, result_o=16384.
- x_i=20480 (1.25): x1=4096, y sequence 12288, 13312, 13056, ...; terminates when |x1_n|<4; result_o within ±4 of 13107.
- x_i=24576 (1.5): converges to 10923 ±4; check sigma_n alternates each MULT and valid_o is one cycle wide.
- x_i=328 (~0.02): slow series; y saturates at 32767, terminates on n=N_MAX=32, valid_o pulse, result_o=32767.
- start_i while busy_i=1 -> ignored, x unchanged. Same-cycle start accept and wren_y -> y=ONE.
